clock_reset_sequencer: RTL and testbench
========================================

// Module: clock_reset_sequencer
// PURPOSE
//  Consumes the PLL lock from the main clock-synthesis stage; produces ordered, per-stage reset requests
//  and a system-ready flag. Holds all downstream logic in reset until lock is stable, then releases
//  stages in index order at fixed spacing. On lock loss or a soft-reset request it re-asserts every
//  stage reset and re-sequences. All outputs are in the clk_125mhz domain.
// PARAMETERS
//  LOCK_STABLE_CYCLES  1250  consecutive synced-lock cycles required before the first release (10 us)
//  STAGE_GAP_CYCLES    16    cycles between successive stage releases, and between the last release and ready
//  NUM_STAGES          3     number of independently released reset outputs (1..8)
//  LOSS_CNT_WIDTH      8     width of the saturating lock-loss counter
// PORTS
//  clk_125mhz      in   1               system clock
//  rst             in   1               synchronous, active-high reset
//  pll_lock        in   1               raw PLL lock, asynchronous to clk_125mhz
//  soft_rst_req    in   1               single-cycle pulse; requests a re-sequence without PLL relock
//  stage_rst       out  NUM_STAGES      active-high reset per stage; bit 0 is released first
//  sys_ready       out  1               high only in RUN
//  lock_loss_count out  LOSS_CNT_WIDTH  number of lock losses seen, saturating
//  seq_state       out  3               current FSM state encoding, for debug
// BEHAVIOUR
//  - Reset: stage_rst all ones; sys_ready 0; lock_loss_count 0; state WAIT_LOCK; synchronizer flops 0.
//    Reset taken mid-sequence behaves identically.
//  - pll_lock passes through a 2-FF synchronizer (lock_s). All outputs are registered.
//  - WAIT_LOCK: stage_rst all ones. If lock_s=1, go to STABILIZE with cnt=0.
//  - STABILIZE: cnt increments each cycle while lock_s=1. At cnt==LOCK_STABLE_CYCLES-1 go to RELEASE;
//    stage_rst[0] deasserts on that same edge, and gap cnt=0.
//  - RELEASE: gap cnt increments each cycle. At STAGE_GAP_CYCLES-1 it wraps to 0 and releases the next
//    stage. After the gap that follows the last stage release, go to RUN and set sys_ready=1.
//  - RUN: holds the state. stage_rst stays all zeros.
//  - Timing: stage_rst[0] falls LOCK_STABLE_CYCLES+3 cycles after a pll_lock rise sampled at clk_125mhz
//    (2 synchronizer cycles + 1 WAIT_LOCK cycle + the stable window). Stage i falls i*STAGE_GAP_CYCLES later.
//    sys_ready rises NUM_STAGES*STAGE_GAP_CYCLES after stage 0 falls.
//  - Lock loss: lock_s=0 while in STABILIZE, RELEASE or RUN. On the next edge: stage_rst all ones,
//    sys_ready 0, go to WAIT_LOCK, and lock_loss_count increments (holds at all ones).
//    The outputs therefore assert 3 cycles after pll_lock falls.
//  - soft_rst_req in STABILIZE, RELEASE or RUN: on the next edge stage_rst all ones, sys_ready 0, go to
//    STABILIZE with cnt=0. No counter change. soft_rst_req is ignored in WAIT_LOCK.
//  - Simultaneous lock loss and soft_rst_req: lock loss wins (WAIT_LOCK, counter increments).
//  - A lock glitch shorter than 1 cycle may be missed by the synchronizer; this is accepted.
//  - stage_rst bits only fall in index order. Any re-assert sets all bits in the same cycle.
//  - Counter widths are $clog2(param)+1. No arithmetic wraps except the gap counter described above.
// STRUCTURE
//  - Shared package clk_rst_pkg: seq_state_t enum (WAIT_LOCK=0, STABILIZE=1, RELEASE=2, RUN=3) and
//    the default timing constants. Other packages reuse these.
//  - One sub-module, pll_lock_sync: 2-FF synchronizer with ASYNC_REG attributes and reset value 0.
//  - Sequencer FSM, counters and output registers live in this module.
// TESTING  (LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4, NUM_STAGES=3)
//  1 rst, then pll_lock rises at cycle 0 -> stage_rst falls 3'b111->110 at cycle 11, 100 at 15,
//    000 at 19; sys_ready=1 at 23; lock_loss_count=0.
//  2 Reach RUN, drop pll_lock at cycle T -> stage_rst=111 and sys_ready=0 at T+3; lock_loss_count=1;
//    relock re-runs scenario 1 timing.
//  3 Drop pll_lock for 3 cycles at stable-window cnt=5 -> return to WAIT_LOCK with no release and
//    count=1; a full 8-cycle window is required after relock.
//  4 Pulse soft_rst_req in RUN -> next cycle stage_rst=111 and sys_ready=0; stage 0 released 8 cycles
//    later; count unchanged.
//  5 soft_rst_req in the same cycle lock_s falls -> WAIT_LOCK and count increments.
//    Separately, soft_rst_req in WAIT_LOCK -> no effect.
//  6 Force 300 lock losses with LOSS_CNT_WIDTH=8 -> lock_loss_count holds at 255.
//    Asserting rst mid-RELEASE -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared clock/reset sequencing types and default timing constants.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABILIZE = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3
    } seq_state_t;

    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1250;
    localparam int unsigned DEF_STAGE_GAP_CYCLES   = 16;
    localparam int unsigned DEF_NUM_STAGES         = 3;
    localparam int unsigned DEF_LOSS_CNT_WIDTH     = 8;

endpackage

// File: rtl/clock_reset_sequencer_if.sv
// Lock input, soft-reset request and sequenced reset/status outputs of the reset sequencer.
interface clock_reset_sequencer_if
    import clk_rst_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = DEF_NUM_STAGES,
    parameter int unsigned LOSS_CNT_WIDTH = DEF_LOSS_CNT_WIDTH
) ();

    logic                      pll_lock;
    logic                      soft_rst_req;
    logic [NUM_STAGES-1:0]     stage_rst;
    logic                      sys_ready;
    logic [LOSS_CNT_WIDTH-1:0] lock_loss_count;
    seq_state_t                seq_state;

    modport master (
        output pll_lock,
        output soft_rst_req,
        input  stage_rst,
        input  sys_ready,
        input  lock_loss_count,
        input  seq_state
    );

    modport slave (
        input  pll_lock,
        input  soft_rst_req,
        output stage_rst,
        output sys_ready,
        output lock_loss_count,
        output seq_state
    );

endinterface

// File: rtl/clock_reset_sequencer_pll_lock_sync.sv
// Two-flop synchronizer bringing the raw PLL lock into the clk_125mhz domain.
module pll_lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/clock_reset_sequencer.sv
// Holds downstream stages in reset until PLL lock is stable, then releases them in index order
// at fixed spacing; re-sequences on lock loss or a soft-reset request.
module clock_reset_sequencer
    import clk_rst_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned STAGE_GAP_CYCLES   = DEF_STAGE_GAP_CYCLES,
    parameter int unsigned NUM_STAGES         = DEF_NUM_STAGES,
    parameter int unsigned LOSS_CNT_WIDTH     = DEF_LOSS_CNT_WIDTH
) (
    input  logic                     clk_125mhz,
    input  logic                     rst,
    clock_reset_sequencer_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int unsigned GAP_W = $clog2(STAGE_GAP_CYCLES) + 1;
    localparam int unsigned IDX_W = $clog2(NUM_STAGES) + 1;

    logic lock_s;

    seq_state_t                state_q,  state_d;
    logic [CNT_W-1:0]          cnt_q,    cnt_d;
    logic [GAP_W-1:0]          gap_q,    gap_d;
    logic [IDX_W-1:0]          idx_q,    idx_d;
    logic [NUM_STAGES-1:0]     stage_q,  stage_d;
    logic                      ready_q,  ready_d;
    logic [LOSS_CNT_WIDTH-1:0] loss_q,   loss_d;

    pll_lock_sync u_lock_sync (
        .clk_i   (clk_125mhz),
        .rst_i   (rst),
        .async_i (bus.pll_lock),
        .sync_o  (lock_s)
    );

    // Next-state logic; lock loss outranks a soft-reset request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        ready_d = ready_q;
        loss_d  = loss_q;

        if (state_q != WAIT_LOCK && !lock_s) begin
            state_d = WAIT_LOCK;
            stage_d = '1;
            ready_d = 1'b0;
            cnt_d   = '0;
            if (loss_q != '1) begin
                loss_d = loss_q + LOSS_CNT_WIDTH'(1);
            end
        end else if (state_q != WAIT_LOCK && bus.soft_rst_req) begin
            state_d = STABILIZE;
            stage_d = '1;
            ready_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    stage_d = '1;
                    ready_d = 1'b0;
                    if (lock_s) begin
                        state_d = STABILIZE;
                        cnt_d   = '0;
                    end
                end
                STABILIZE: begin
                    if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state_d = RELEASE;
                        stage_d = {NUM_STAGES{1'b1}} << 1;
                        gap_d   = '0;
                        idx_d   = IDX_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (gap_q == GAP_W'(STAGE_GAP_CYCLES - 1)) begin
                        gap_d = '0;
                        // idx_q counts stages already released; all released means ready.
                        if (idx_q == IDX_W'(NUM_STAGES)) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            stage_d = stage_q << 1;
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                RUN: begin
                    stage_d = '0;
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    stage_d = '1;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            stage_q <= '1;
            ready_q <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            ready_q <= ready_d;
            loss_q  <= loss_d;
        end
    end

    assign bus.stage_rst       = stage_q;
    assign bus.sys_ready       = ready_q;
    assign bus.lock_loss_count = loss_q;
    assign bus.seq_state       = state_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Self-checking bench for clock_reset_sequencer: timing table, corner-case sequences and
// randomized lock/soft-reset traffic against an elapsed-time reference model.
module tb_clock_reset_sequencer;
    import clk_rst_pkg::*;

    localparam int L  = 8;
    localparam int G  = 4;
    localparam int N  = 3;
    localparam int LW = 8;
    localparam int LOSS_MAX = (1 << LW) - 1;

    logic clk_125mhz = 1'b0;
    logic rst;

    always #4 clk_125mhz = ~clk_125mhz;

    clock_reset_sequencer_if #(.NUM_STAGES(N), .LOSS_CNT_WIDTH(LW)) bus ();

    clock_reset_sequencer #(
        .LOCK_STABLE_CYCLES (L),
        .STAGE_GAP_CYCLES   (G),
        .NUM_STAGES         (N),
        .LOSS_CNT_WIDTH     (LW)
    ) dut (
        .clk_125mhz (clk_125mhz),
        .rst        (rst),
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a 2-deep lock delay plus "when did the current sequence start".
    int k       = 0;
    bit m_wait  = 1'b1;
    int m_start = 0;
    int m_loss  = 0;
    bit s1      = 1'b0;
    bit s2      = 1'b0;

    function automatic logic [N-1:0] exp_stage();
        logic [N-1:0] r;
        int e;
        e = k - m_start;
        for (int i = 0; i < N; i++) r[i] = m_wait ? 1'b1 : (e < L + i * G);
        return r;
    endfunction

    function automatic int exp_state();
        int e;
        e = k - m_start;
        if (m_wait)           return 0;
        else if (e < L)       return 1;
        else if (e < L + N*G) return 2;
        else                  return 3;
    endfunction

    function automatic bit exp_ready();
        return !m_wait && ((k - m_start) >= L + N * G);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, k, got, exp);
        end
    endtask

    task automatic model_edge();
        bit ls;
        ls = s2;
        k++;
        if (rst) begin
            m_wait = 1'b1;
            m_loss = 0;
            s1 = 1'b0;
            s2 = 1'b0;
        end else begin
            s2 = s1;
            s1 = bus.pll_lock;
            if (m_wait) begin
                if (ls) begin
                    m_wait  = 1'b0;
                    m_start = k;
                end
            end else if (!ls) begin
                m_wait = 1'b1;
                if (m_loss < LOSS_MAX) m_loss++;
            end else if (bus.soft_rst_req) begin
                m_start = k;
            end
        end
    endtask

    // One clock: model steps on the edge, outputs are checked on the falling edge.
    task automatic cycle();
        @(posedge clk_125mhz);
        model_edge();
        @(negedge clk_125mhz);
        chk("model_stage", 32'(bus.stage_rst), 32'(exp_stage()));
        chk("model_ready", 32'(bus.sys_ready), 32'(exp_ready()));
        chk("model_state", 32'(bus.seq_state), 32'(exp_state()));
        chk("model_count", 32'(bus.lock_loss_count), 32'(m_loss));
    endtask

    task automatic run_to(input int t);
        while (k < t) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.soft_rst_req = 1'b0;
        bus.pll_lock = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    typedef struct {
        int         cyc;
        logic [2:0] stage;
        logic       ready;
        logic [2:0] state;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int r;
        int s;
        int x;

        tbl[0] = '{2,  3'b111, 1'b0, 3'd0};
        tbl[1] = '{3,  3'b111, 1'b0, 3'd1};
        tbl[2] = '{10, 3'b111, 1'b0, 3'd1};
        tbl[3] = '{11, 3'b110, 1'b0, 3'd2};
        tbl[4] = '{14, 3'b110, 1'b0, 3'd2};
        tbl[5] = '{15, 3'b100, 1'b0, 3'd2};
        tbl[6] = '{19, 3'b000, 1'b0, 3'd2};
        tbl[7] = '{22, 3'b000, 1'b0, 3'd2};
        tbl[8] = '{23, 3'b000, 1'b1, 3'd3};

        rst = 1'b1;
        bus.pll_lock = 1'b0;
        bus.soft_rst_req = 1'b0;

        // Reset values, then nominal lock-up timing.
        do_reset();
        chk("rst_stage", 32'(bus.stage_rst), 32'h7);
        chk("rst_ready", 32'(bus.sys_ready), 32'h0);
        chk("rst_count", 32'(bus.lock_loss_count), 32'h0);
        chk("rst_state", 32'(bus.seq_state), 32'h0);
        bus.pll_lock = 1'b1;
        r = k;
        for (int i = 0; i < 9; i++) begin
            run_to(r + tbl[i].cyc);
            chk("tbl_stage", 32'(bus.stage_rst), 32'(tbl[i].stage));
            chk("tbl_ready", 32'(bus.sys_ready), 32'(tbl[i].ready));
            chk("tbl_state", 32'(bus.seq_state), 32'(tbl[i].state));
        end
        chk("tbl_count", 32'(bus.lock_loss_count), 32'h0);

        // Lock loss in RUN: outputs assert three edges later; relock repeats the timing.
        run_to(k + 3);
        bus.pll_lock = 1'b0;
        r = k;
        run_to(r + 2);
        chk("loss_pre_ready", 32'(bus.sys_ready), 32'h1);
        run_to(r + 3);
        chk("loss_stage", 32'(bus.stage_rst), 32'h7);
        chk("loss_ready", 32'(bus.sys_ready), 32'h0);
        chk("loss_count", 32'(bus.lock_loss_count), 32'h1);
        bus.pll_lock = 1'b1;
        r = k;
        run_to(r + 10);
        chk("relock_hold", 32'(bus.stage_rst), 32'h7);
        run_to(r + 11);
        chk("relock_rel0", 32'(bus.stage_rst), 32'h6);
        run_to(r + 23);
        chk("relock_ready", 32'(bus.sys_ready), 32'h1);

        // Short lock drop inside the stable window aborts it; a full window follows relock.
        do_reset();
        bus.pll_lock = 1'b1;
        r = k;
        run_to(r + 8);
        bus.pll_lock = 1'b0;
        run_to(r + 11);
        bus.pll_lock = 1'b1;
        chk("glitch_state", 32'(bus.seq_state), 32'h0);
        chk("glitch_stage", 32'(bus.stage_rst), 32'h7);
        chk("glitch_count", 32'(bus.lock_loss_count), 32'h1);
        run_to(r + 21);
        chk("glitch_hold", 32'(bus.stage_rst), 32'h7);
        run_to(r + 22);
        chk("glitch_rel0", 32'(bus.stage_rst), 32'h6);
        run_to(r + 34);
        chk("glitch_ready", 32'(bus.sys_ready), 32'h1);

        // Soft reset in RUN.
        bus.soft_rst_req = 1'b1;
        cycle();
        bus.soft_rst_req = 1'b0;
        s = k;
        chk("soft_stage", 32'(bus.stage_rst), 32'h7);
        chk("soft_ready", 32'(bus.sys_ready), 32'h0);
        chk("soft_state", 32'(bus.seq_state), 32'h1);
        chk("soft_count", 32'(bus.lock_loss_count), 32'h1);
        run_to(s + 7);
        chk("soft_hold", 32'(bus.stage_rst), 32'h7);
        run_to(s + 8);
        chk("soft_rel0", 32'(bus.stage_rst), 32'h6);
        run_to(s + 20);
        chk("soft_ready2", 32'(bus.sys_ready), 32'h1);

        // Soft reset coinciding with synced lock loss: loss wins.
        bus.pll_lock = 1'b0;
        r = k;
        run_to(r + 2);
        bus.soft_rst_req = 1'b1;
        cycle();
        bus.soft_rst_req = 1'b0;
        chk("both_state", 32'(bus.seq_state), 32'h0);
        chk("both_count", 32'(bus.lock_loss_count), 32'h2);
        // Soft reset in WAIT_LOCK is ignored.
        bus.soft_rst_req = 1'b1;
        cycle();
        bus.soft_rst_req = 1'b0;
        chk("wait_soft_state", 32'(bus.seq_state), 32'h0);
        run_to(k + 3);
        chk("wait_soft_state2", 32'(bus.seq_state), 32'h0);
        chk("wait_soft_stage", 32'(bus.stage_rst), 32'h7);

        // Saturating loss counter.
        for (int i = 0; i < 300; i++) begin
            bus.pll_lock = 1'b1;
            run_to(k + 4);
            bus.pll_lock = 1'b0;
            run_to(k + 4);
        end
        chk("sat_count", 32'(bus.lock_loss_count), 32'd255);

        // Reset mid-RELEASE, including the synchronizer.
        bus.pll_lock = 1'b1;
        r = k;
        run_to(r + 13);
        chk("midrel_state", 32'(bus.seq_state), 32'h2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        x = k;
        chk("midrst_stage", 32'(bus.stage_rst), 32'h7);
        chk("midrst_ready", 32'(bus.sys_ready), 32'h0);
        chk("midrst_count", 32'(bus.lock_loss_count), 32'h0);
        chk("midrst_state", 32'(bus.seq_state), 32'h0);
        run_to(x + 2);
        chk("midrst_sync", 32'(bus.seq_state), 32'h0);
        run_to(x + 10);
        chk("midrst_hold", 32'(bus.stage_rst), 32'h7);
        run_to(x + 11);
        chk("midrst_rel0", 32'(bus.stage_rst), 32'h6);

        // Randomized lock toggles, glitches, soft pulses and resets against the model.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 59) == 0) bus.pll_lock = ~bus.pll_lock;
            bus.soft_rst_req = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 699) == 0);
            cycle();
        end
        rst = 1'b0;
        bus.soft_rst_req = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
